mem_arbiter: RTL and testbench

- Shares one synchronous single-port memory between two requesters: the instruction-fetch path (read-only, I port) and the load/store path (read/write, D port).
- Round-robin arbitration between the two ports.
- Issues one access per grant and steers the read data (or write acknowledge) back to the owning port after a fixed memory latency.
- Placed between the program counter / fetch logic, the load/store datapath and the unified memory.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (I) and load/store (D).
// Grants are combinational; rdata/rvalid are steered to the owner exactly MEM_LATENCY cycles after issue.
module mem_arbiter #(
  parameter int A_WIDTH     = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [A_WIDTH-1:0]    i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [A_WIDTH-1:0]    d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [A_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  port_t      owner_q, owner_d;
  port_t      last_q, last_d;

  logic  cmpl;
  logic  arb_ok;
  logic  gnt_vld;
  port_t gnt_port;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      owner_q <= PORT_D;
      last_q  <= PORT_D;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    cmpl     = (state_q == ST_WAIT) && (cnt_q == LAT);
    // Gate with rst so no grant can leak out while reset is held.
    arb_ok   = rst && ((state_q == ST_IDLE) || cmpl);
    gnt_vld  = 1'b0;
    gnt_port = PORT_I;
    if (arb_ok) begin
      if (i_req && d_req) begin
        gnt_vld  = 1'b1;
        gnt_port = (last_q == PORT_D) ? PORT_I : PORT_D;
      end else if (i_req) begin
        gnt_vld  = 1'b1;
        gnt_port = PORT_I;
      end else if (d_req) begin
        gnt_vld  = 1'b1;
        gnt_port = PORT_D;
      end
    end
  end

  always_comb begin
    i_gnt     = gnt_vld && (gnt_port == PORT_I);
    d_gnt     = gnt_vld && (gnt_port == PORT_D);
    mem_en    = gnt_vld;
    mem_we    = d_gnt && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr;
    end
    i_rvalid = cmpl && (owner_q == PORT_I);
    d_rvalid = cmpl && (owner_q == PORT_D);
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
    busy     = (state_q == ST_WAIT);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (gnt_vld) begin
      // A grant in the completion cycle re-arms the counter back-to-back.
      state_d = ST_WAIT;
      cnt_d   = 3'd1;
      owner_d = gnt_port;
      last_d  = gnt_port;
    end else if (cmpl) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench: two arbiters (latency 1 and 3) against a cycle-number based reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit fin [2];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int k);
    return 32'hA5A5_0000 ^ (32'(k) * 32'h9E37_79B9);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 1 : 3;

    logic          rst;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.A_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory model: 16 words, read data appears LAT cycles after issue, garbage otherwise.
    logic [DW-1:0] mem  [16];
    logic [DW-1:0] pipe [1:7];
    bit            mem_ok = 1'b0;
    assign mem_rdata = pipe[LAT];

    always @(posedge clk) begin
      for (int k = 7; k > 1; k--) pipe[k] <= pipe[k-1];
      if (mem_en && !mem_we) pipe[1] <= mem[mem_addr[3:0]];
      else                   pipe[1] <= $urandom;
      if (!mem_ok) begin
        for (int k = 0; k < 16; k++) mem[k] <= init_word(k);
        mem_ok <= 1'b1;
      end else if (mem_en && mem_we) begin
        mem[mem_addr[3:0]] <= mem_wdata;
      end
    end

    initial begin : drive
      logic [DW-1:0] ref_mem [16];
      logic [DW-1:0] cdata, e_wdata;
      logic [AW-1:0] e_addr;
      int  cyc, free_at, cmpl_at, own, last, gp;
      bit  cstore, did_rst, g_vld, cm;

      for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);
      cdata = '0; cstore = 1'b0; did_rst = 1'b0;
      rst = 1'b0;
      i_req = 1'b1; i_addr = $urandom;
      d_req = 1'b1; d_we = 1'b0; d_addr = $urandom; d_wdata = $urandom;

      // Requests held high during reset must not produce any output activity.
      @(negedge clk);
      chk_eq("rst_i_gnt", i_gnt, 0);
      chk_eq("rst_d_gnt", d_gnt, 0);
      chk_eq("rst_mem_en", mem_en, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_rvalid", {i_rvalid, d_rvalid}, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      cyc = 0; free_at = 0; cmpl_at = -1; own = 1; last = 1;

      for (int n = 0; n < 600; n++) begin
        @(negedge clk);
        g_vld = 1'b0; gp = 0;
        if (cyc >= free_at) begin
          if (i_req && d_req) begin g_vld = 1'b1; gp = (last == 1) ? 0 : 1; end
          else if (i_req)     begin g_vld = 1'b1; gp = 0; end
          else if (d_req)     begin g_vld = 1'b1; gp = 1; end
        end
        e_addr  = !g_vld ? '0 : ((gp == 1) ? d_addr : i_addr);
        e_wdata = (g_vld && gp == 1) ? d_wdata : '0;
        cm = (cyc == cmpl_at);

        chk_eq("i_gnt", i_gnt, g_vld && gp == 0);
        chk_eq("d_gnt", d_gnt, g_vld && gp == 1);
        chk_eq("mem_en", mem_en, g_vld);
        chk_eq("mem_addr", mem_addr, e_addr);
        chk_eq("mem_we", mem_we, g_vld && gp == 1 && d_we);
        chk_eq("mem_wdata", mem_wdata, e_wdata);
        chk_eq("i_rvalid", i_rvalid, cm && own == 0);
        chk_eq("d_rvalid", d_rvalid, cm && own == 1);
        chk_eq("i_rdata", i_rdata, (cm && own == 0) ? cdata : '0);
        if (!(cm && own == 1 && cstore))
          chk_eq("d_rdata", d_rdata, (cm && own == 1) ? cdata : '0);
        chk_eq("busy", busy, (cyc > cmpl_at - LAT) && (cyc <= cmpl_at));

        if (g_vld) begin
          free_at = cyc + LAT;
          cmpl_at = cyc + LAT;
          own = gp; last = gp;
          if (gp == 1 && d_we) begin
            ref_mem[d_addr[3:0]] = d_wdata;
            cstore = 1'b1;
          end else begin
            cstore = 1'b0;
            cdata  = ref_mem[e_addr[3:0]];
          end
        end

        @(posedge clk); #1;
        cyc++;
        // Requesters: hold until granted, occasionally drop early; both held for the first 30 cycles.
        if (g_vld && gp == 0) begin
          i_req = (cyc <= 30) || ($urandom_range(0, 3) != 0); i_addr = $urandom;
        end else if (i_req && cyc > 30 && $urandom_range(0, 15) == 0) begin
          i_req = 1'b0;
        end else if (!i_req) begin
          i_req = $urandom_range(0, 1); i_addr = $urandom;
        end
        if (g_vld && gp == 1) begin
          d_req = (cyc <= 30) || ($urandom_range(0, 3) != 0);
          d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
        end else if (d_req && cyc > 30 && $urandom_range(0, 15) == 0) begin
          d_req = 1'b0;
        end else if (!d_req) begin
          d_req = $urandom_range(0, 1);
          d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
        end

        // Asynchronous reset one cycle after a grant, while that access is outstanding.
        if (!did_rst && cyc >= 300 && cmpl_at == cyc + LAT - 1) begin
          did_rst = 1'b1;
          #2 rst = 1'b0;
          #1;
          chk_eq("arst_busy", busy, 0);
          chk_eq("arst_rvalid", {i_rvalid, d_rvalid}, 0);
          chk_eq("arst_gnt", {i_gnt, d_gnt}, 0);
          chk_eq("arst_mem_en", mem_en, 0);
          cmpl_at = -1; own = 1; last = 1;
          @(posedge clk); #3;
          rst = 1'b1;
          cyc++;
          free_at = cyc;
        end
      end
      chk_eq("reset_exercised", did_rst, 1);
      fin[g] = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 5000 && !(fin[0] && fin[1]); t++) @(posedge clk);
    chk_eq("bench_done", {fin[0], fin[1]}, 2'b11);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
